// File: rtl/data_mem_responder_if.sv
// Load/store request port between processor and data memory responder.
// master = processor datapath, slave = memory responder.
interface data_mem_responder_if #(
  parameter int DATA_LEN = 16,
  parameter int ADDR_LEN = 8
);
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_LEN-1:0] mem_addr;
  logic [DATA_LEN-1:0] mem_wdata;
  logic [DATA_LEN-1:0] mem_rdata;
  logic                mem_ack;
  logic                mem_busy;
  logic                mem_err;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack, mem_busy, mem_err
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack, mem_busy, mem_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-port data RAM behind a req/ack port with programmable wait states.
// Define DMEM_ADDR_CHECK_EN to flag and suppress accesses at addr >= MEM_DEPTH.
module data_mem_responder #(
  parameter int DATA_LEN    = 16,
  parameter int ADDR_LEN    = 8,
  parameter int MEM_DEPTH   = 128,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic                we_q;
  logic [ADDR_LEN-1:0] addr_q;
  logic [DATA_LEN-1:0] wdata_q;

  logic [DATA_LEN-1:0] ram [MEM_DEPTH];

  logic                acc_we;
  logic [ADDR_LEN-1:0] acc_addr;
  logic [DATA_LEN-1:0] acc_wdata;
  logic [IDX_W-1:0]    idx;
  logic                in_range;
  logic                go_resp;
  logic                commit;

  // With zero wait states the access happens on the capture edge itself,
  // so the live bus values stand in for the not-yet-latched ones.
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state == IDLE) begin
      acc_we    = bus.mem_we;
      acc_addr  = bus.mem_addr;
      acc_wdata = bus.mem_wdata;
    end
  end

  assign idx = IDX_W'({1'b0, acc_addr} % (ADDR_LEN+1)'(MEM_DEPTH));

`ifdef DMEM_ADDR_CHECK_EN
  assign in_range = {1'b0, acc_addr} < (ADDR_LEN+1)'(MEM_DEPTH);
`else
  assign in_range = 1'b1;
`endif

  assign go_resp =
    ((state == IDLE) && bus.mem_req && (WAIT_STATES == 0)) ||
    ((state == WAIT) && (cnt == 4'd1));

  assign commit = go_resp && acc_we && in_range && reset;

  always_ff @(posedge clk) begin
    if (commit) ram[idx] <= acc_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      bus.mem_ack   <= 1'b0;
      bus.mem_busy  <= 1'b0;
      bus.mem_err   <= 1'b0;
      bus.mem_rdata <= '0;
    end else begin
      bus.mem_ack <= 1'b0;
      bus.mem_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.mem_req) begin
            we_q         <= bus.mem_we;
            addr_q       <= bus.mem_addr;
            wdata_q      <= bus.mem_wdata;
            cnt          <= 4'(WAIT_STATES);
            bus.mem_busy <= 1'b1;
            state        <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          bus.mem_busy <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (go_resp) begin
        bus.mem_ack <= 1'b1;
        bus.mem_err <= !in_range;
        if (!acc_we) bus.mem_rdata <= in_range ? ram[idx] : '0;
      end
    end
  end

endmodule
